// File: rtl/nbit_alu_pkg.sv
// nbit_alu_pkg: alufn operation codes shared by the ALU and ALU control.
// Pure constants; no timing or flow control.
package nbit_alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_PASS = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_ROL  = 4'b1011;
  localparam logic [3:0] ALU_ROR  = 4'b1100;
  localparam logic [3:0] ALU_SLT  = 4'b1101;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

endpackage

// File: rtl/nbit_alu_shifter.sv
// nbit_alu_shifter: combinational SRL/SLL/SRA (+ROL/ROR with NBIT_ALU_ROTATE_EN), 0 for other codes.
// Zero latency, no flow control.
module nbit_alu_shifter
  import nbit_alu_pkg::*;
#(
  parameter int N  = 32,
  parameter int SW = $clog2(N)
) (
  input  logic [3:0]    op,
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] shamt,
  output logic [N-1:0]  y
);

`ifdef NBIT_ALU_ROTATE_EN
  logic [2*N-1:0] rol_w;
  logic [2*N-1:0] ror_w;

  // Shifting a doubled copy of A makes the wrap-around bits fall into place.
  assign rol_w = {a, a} << shamt;
  assign ror_w = {a, a} >> shamt;
`endif

  always_comb begin
    y = '0;
    case (op)
      ALU_SRL: y = a >> shamt;
      ALU_SLL: y = a << shamt;
      ALU_SRA: y = $signed(a) >>> shamt;
`ifdef NBIT_ALU_ROTATE_EN
      ALU_ROL: y = rol_w[2*N-1:N];
      ALU_ROR: y = ror_w[N-1:0];
`endif
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/nbit_alu.sv
// nbit_alu: registered N-bit ALU with adder-derived flags; optional rotates via NBIT_ALU_ROTATE_EN.
// Latency 1 cycle, new operation every cycle, no backpressure.
module nbit_alu
  import nbit_alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   alufn,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] C,
  output logic         ZeroFlag,
  output logic         CarryFlag,
  output logic         OverflowFlag,
  output logic         SignFlag
);

  localparam int SW = $clog2(N);

  logic         sub;
  logic [N-1:0] b_op;
  logic [N:0]   add_full;
  logic [N-1:0] sum;
  logic [N-1:0] shift_y;
  logic [N-1:0] c_next;
  logic         zero_next;
  logic         carry_next;
  logic         ovf_next;
  logic         sign_next;

  // One adder serves every code so branch logic can use any subtract-class alufn.
  assign sub        = alufn[0];
  assign b_op       = sub ? ~B : B;
  assign add_full   = {1'b0, A} + {1'b0, b_op} + {{N{1'b0}}, sub};
  assign sum        = add_full[N-1:0];
  assign carry_next = add_full[N];
  assign zero_next  = (sum == '0);
  assign sign_next  = sum[N-1];
  assign ovf_next   = (A[N-1] == b_op[N-1]) && (sum[N-1] != A[N-1]);

  nbit_alu_shifter #(.N(N), .SW(SW)) u_shifter (
    .op    (alufn),
    .a     (A),
    .shamt (B[SW-1:0]),
    .y     (shift_y)
  );

  always_comb begin
    c_next = '0;
    case (alufn)
      ALU_ADD,
      ALU_SUB:  c_next = sum;
      ALU_PASS: c_next = B;
      ALU_OR:   c_next = A | B;
      ALU_AND:  c_next = A & B;
      ALU_XOR:  c_next = A ^ B;
      ALU_SRL,
      ALU_SLL,
      ALU_SRA:  c_next = shift_y;
`ifdef NBIT_ALU_ROTATE_EN
      ALU_ROL,
      ALU_ROR:  c_next = shift_y;
`endif
      ALU_SLT:  c_next = {{(N-1){1'b0}}, sign_next ^ ovf_next};
      ALU_SLTU: c_next = {{(N-1){1'b0}}, ~carry_next};
      default:  c_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      C            <= '0;
      ZeroFlag     <= 1'b0;
      CarryFlag    <= 1'b0;
      OverflowFlag <= 1'b0;
      SignFlag     <= 1'b0;
    end else begin
      C            <= c_next;
      ZeroFlag     <= zero_next;
      CarryFlag    <= carry_next;
      OverflowFlag <= ovf_next;
      SignFlag     <= sign_next;
    end
  end

endmodule

// File: tb/tb_nbit_alu.sv
// Scoreboard bench for nbit_alu (N=32): directed cases plus random ops against an arithmetic model.
module tb_nbit_alu;

  localparam int N = 32;

  typedef struct {
    string       tag;
    logic [31:0] c;
    logic        z;
    logic        cy;
    logic        v;
    logic        s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  alufn = 4'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] C;
  logic        ZeroFlag, CarryFlag, OverflowFlag, SignFlag;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  nbit_alu #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alufn        (alufn),
    .A            (A),
    .B            (B),
    .C            (C),
    .ZeroFlag     (ZeroFlag),
    .CarryFlag    (CarryFlag),
    .OverflowFlag (OverflowFlag),
    .SignFlag     (SignFlag)
  );

  always #5 clk = ~clk;

  // Reference model: flags from true integer arithmetic, result from the op table.
  function automatic exp_t model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, ssum;
    logic [32:0] full;
    logic [31:0] res;
    logic signed [31:0] sra_v;
    logic [63:0] dbl;
    int          sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (f[0]) begin
      res  = a - b;
      e.cy = (a >= b);
      ssum = sa - sb;
    end else begin
      full = {1'b0, a} + {1'b0, b};
      res  = full[31:0];
      e.cy = full[32];
      ssum = sa + sb;
    end
    e.z = (res == 32'd0);
    e.s = res[31];
    e.v = (ssum != longint'($signed(res)));
    sh  = int'(b[4:0]);
    sra_v = $signed(a) >>> sh;
    dbl = {a, a};
    case (f)
      4'd0, 4'd1: e.c = res;
      4'd3:  e.c = b;
      4'd4:  e.c = a | b;
      4'd5:  e.c = a & b;
      4'd7:  e.c = a ^ b;
      4'd8:  e.c = a >> sh;
      4'd9:  e.c = a << sh;
      4'd10: e.c = sra_v;
`ifdef NBIT_ALU_ROTATE_EN
      4'd11: begin dbl = dbl << sh; e.c = dbl[63:32]; end
      4'd12: begin dbl = dbl >> sh; e.c = dbl[31:0]; end
`endif
      4'd13: e.c = {31'd0, sa < sb};
      4'd15: e.c = {31'd0, a < b};
      default: e.c = 32'd0;
    endcase
    e.tag = $sformatf("op%0d a=%h b=%h", f, a, b);
    return e;
  endfunction

  task automatic issue(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    rst_n = 1'b1;
    alufn = f;
    A     = a;
    B     = b;
    exp_q.push_back(model(f, a, b));
  endtask

  task automatic do_reset(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    rst_n = 1'b0;
    alufn = f;
    A     = a;
    B     = b;
    e = '{tag: "reset", c: 32'd0, z: 1'b0, cy: 1'b0, v: 1'b0, s: 1'b0};
    exp_q.push_back(e);
  endtask

  // Monitor: one registered result per rising edge once something is expected.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (C !== e.c || ZeroFlag !== e.z || CarryFlag !== e.cy ||
          OverflowFlag !== e.v || SignFlag !== e.s) begin
        n_fail++;
        $display("FAIL %s: got C=%h Z%b C%b V%b S%b, want C=%h Z%b C%b V%b S%b",
                 e.tag, C, ZeroFlag, CarryFlag, OverflowFlag, SignFlag,
                 e.c, e.z, e.cy, e.v, e.s);
      end
    end
  end

  function automatic logic [31:0] pick();
    logic [31:0] corner [6];
    corner = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000001};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 5)];
    return $urandom();
  endfunction

  initial begin
    exp_t e;
    do_reset(4'd0, 32'd0, 32'd0);
    do_reset(4'd0, 32'd3, 32'd4);

    // Directed cases; hard constants guard against a shared model error.
    issue(4'b1001, 32'hFFFFFFF0, 32'd1);
    e = '{tag: "sll_const", c: 32'hFFFFFFE0, z: 1'b0, cy: 1'b1, v: 1'b0, s: 1'b1};
    exp_q[exp_q.size()-1] = e;
    issue(4'b0000, 32'h7FFFFFFF, 32'd1);
    e = '{tag: "add_ovf_const", c: 32'h80000000, z: 1'b0, cy: 1'b0, v: 1'b1, s: 1'b1};
    exp_q[exp_q.size()-1] = e;
    issue(4'b0001, 32'd5, 32'd5);
    e = '{tag: "sub_eq_const", c: 32'd0, z: 1'b1, cy: 1'b1, v: 1'b0, s: 1'b0};
    exp_q[exp_q.size()-1] = e;
    issue(4'b1101, 32'hFFFFFFFF, 32'd1);
    exp_q[exp_q.size()-1].c = 32'd1;
    issue(4'b1111, 32'hFFFFFFFF, 32'd1);
    exp_q[exp_q.size()-1].c = 32'd0;
    issue(4'b1010, 32'h80000000, 32'h24);
    exp_q[exp_q.size()-1].c = 32'hF8000000;
    issue(4'b1000, 32'h80000000, 32'h24);
    exp_q[exp_q.size()-1].c = 32'h08000000;
    issue(4'b0110, 32'h80000000, 32'h24);
    exp_q[exp_q.size()-1].c = 32'd0;
    issue(4'b0011, 32'h12345678, 32'hCAFEF00D);
    issue(4'b1001, 32'h00000001, 32'h0000001F);
    issue(4'b1000, 32'hDEADBEEF, 32'h00000020);
    issue(4'b1011, 32'h80000001, 32'd1);
`ifdef NBIT_ALU_ROTATE_EN
    exp_q[exp_q.size()-1].c = 32'h00000003;
`else
    exp_q[exp_q.size()-1].c = 32'd0;
`endif
    issue(4'b1100, 32'h80000001, 32'd1);

    // Reset mid-stream, then the first ADD after release.
    for (int i = 0; i < 4; i++) issue(4'b0000, 32'd100 + i, 32'd7);
    do_reset(4'b0000, 32'h7FFFFFFF, 32'd1);
    issue(4'b0000, 32'd10, 32'd20);
    exp_q[exp_q.size()-1].c = 32'd30;
    issue(4'b0001, 32'd0, 32'h80000000);

    for (int i = 0; i < 400; i++)
      issue(4'($urandom_range(0, 15)), pick(), pick());

    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
